// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// mem_op codes, FSM state encoding and default parameters.
package lsu_pkg;

   localparam int XLEN_DEF    = 32;
   localparam int TIMEOUT_DEF = 255;

   localparam logic [2:0] MOP_B  = 3'b000;
   localparam logic [2:0] MOP_H  = 3'b001;
   localparam logic [2:0] MOP_W  = 3'b010;
   localparam logic [2:0] MOP_BU = 3'b100;
   localparam logic [2:0] MOP_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store masks/data, load extraction.
// Also flags misaligned accesses and mem_op codes illegal for the direction.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [2:0]      mem_op,
   input  logic            we,
   input  logic [1:0]      off,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] bus_rdata,
   output logic [3:0]      wmask,
   output logic [XLEN-1:0] wdata_sh,
   output logic [XLEN-1:0] rdata_ext,
   output logic            illegal
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Decode mem_op into lane mask, replicated store data and extended load data
   always_comb begin
      byte_v    = 8'(bus_rdata >> {off, 3'b000});
      half_v    = 16'(bus_rdata >> {off[1], 4'b0000});
      wmask     = 4'b0000;
      wdata_sh  = '0;
      rdata_ext = '0;
      illegal   = 1'b1;
      case (mem_op)
         MOP_B: begin
            illegal   = 1'b0;
            rdata_ext = {{(XLEN-8){byte_v[7]}}, byte_v};
            if (we) begin
               wmask    = 4'b0001 << off;
               wdata_sh = {(XLEN/8){wdata[7:0]}};
            end
         end
         MOP_H: begin
            illegal   = off[0];
            rdata_ext = {{(XLEN-16){half_v[15]}}, half_v};
            if (we) begin
               wmask    = 4'b0011 << off;
               wdata_sh = {(XLEN/16){wdata[15:0]}};
            end
         end
         MOP_W: begin
            illegal   = |off;
            rdata_ext = bus_rdata;
            if (we) begin
               wmask    = 4'b1111;
               wdata_sh = wdata;
            end
         end
         MOP_BU: begin
            illegal   = we;
            rdata_ext = {{(XLEN-8){1'b0}}, byte_v};
         end
         MOP_HU: begin
            illegal   = we | off[0];
            rdata_ext = {{(XLEN-16){1'b0}}, half_v};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: EXU request -> single outstanding bus access -> WBU response.
// Optional bus response watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int XLEN           = XLEN_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            mem_rd,
   input  logic            mem_wr,
   input  logic [2:0]      mem_op,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] rdata,
   output logic            resp_err,
   output logic            bus_req_valid,
   input  logic            bus_req_ready,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_addr,
   output logic [XLEN-1:0] bus_wdata,
   output logic [3:0]      bus_wmask,
   input  logic            bus_resp_valid,
   input  logic [XLEN-1:0] bus_rdata
);

   state_e            state_q, state_d;
   logic              rd_q, rd_d;
   logic              we_q, we_d;
   logic [2:0]        op_q, op_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              idle;
   logic [2:0]        al_op;
   logic              al_we;
   logic [1:0]        al_off;
   logic [3:0]        al_wmask;
   logic [XLEN-1:0]   al_wdata;
   logic [XLEN-1:0]   al_rdata;
   logic              al_illegal;

`ifdef LSU_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ?
                       8 : $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0]     cnt_q, cnt_d;
`else
   logic              unused_timeout;
   assign unused_timeout = |TIMEOUT_CYCLES;
`endif

   // In IDLE the aligner checks the incoming request, otherwise the latched one
   assign idle   = (state_q == S_IDLE);
   assign al_op  = idle ? mem_op     : op_q;
   assign al_we  = idle ? mem_wr     : we_q;
   assign al_off = idle ? addr[1:0]  : addr_q[1:0];

   lsu_align #(.XLEN(XLEN)) u_align (
      .mem_op    (al_op),
      .we        (al_we),
      .off       (al_off),
      .wdata     (wdata_q),
      .bus_rdata (bus_rdata),
      .wmask     (al_wmask),
      .wdata_sh  (al_wdata),
      .rdata_ext (al_rdata),
      .illegal   (al_illegal)
   );

   // State and request/response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         rd_q    <= 1'b0;
         we_q    <= 1'b0;
         op_q    <= 3'b000;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         we_q    <= we_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
`ifdef LSU_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Next state: accept, bus handshake, capture and watchdog
   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      we_d    = we_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
`ifdef LSU_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               rd_d    = mem_rd;
               we_d    = mem_wr;
               op_d    = mem_op;
               addr_d  = addr;
               wdata_d = wdata;
               rdata_d = '0;
               err_d   = 1'b0;
               if (!mem_rd && !mem_wr) begin
                  state_d = S_DONE;
               end else if ((mem_rd && mem_wr) || al_illegal) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_REQ;
`ifdef LSU_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end
            end
         end
         S_REQ: begin
            if (bus_req_ready && bus_resp_valid) begin
               state_d = S_DONE;
               rdata_d = rd_q ? al_rdata : '0;
            end else if (bus_req_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus_resp_valid) begin
               state_d = S_DONE;
               rdata_d = rd_q ? al_rdata : '0;
            end
         end
         S_DONE: begin
            if (resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
`ifdef LSU_TIMEOUT_EN
      if ((state_q == S_REQ || state_q == S_WAIT) && state_d != S_DONE) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
         end
      end
`endif
   end

   // Outputs: handshakes from state, bus fields driven only while requesting
   always_comb begin
      req_ready     = (state_q == S_IDLE);
      resp_valid    = (state_q == S_DONE);
      rdata         = rdata_q;
      resp_err      = err_q;
      bus_req_valid = (state_q == S_REQ);
      bus_we        = 1'b0;
      bus_addr      = '0;
      bus_wdata     = '0;
      bus_wmask     = 4'b0000;
      if (state_q == S_REQ) begin
         bus_we    = we_q;
         bus_addr  = {addr_q[XLEN-1:2], 2'b00};
         bus_wdata = al_wdata;
         bus_wmask = al_wmask;
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed testbench for lsu_ctrl.
// Define LSU_TIMEOUT_EN to exercise the watchdog instead of the endless wait.
module tb_lsu_ctrl;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        mem_rd;
   logic        mem_wr;
   logic [2:0]  mem_op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] rdata;
   logic        resp_err;
   logic        bus_req_valid;
   logic        bus_req_ready;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wmask;
   logic        bus_resp_valid;
   logic [31:0] bus_rdata;

   int n_chk  = 0;
   int n_pass = 0;

   lsu_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .mem_rd         (mem_rd),
      .mem_wr         (mem_wr),
      .mem_op         (mem_op),
      .addr           (addr),
      .wdata          (wdata),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .rdata          (rdata),
      .resp_err       (resp_err),
      .bus_req_valid  (bus_req_valid),
      .bus_req_ready  (bus_req_ready),
      .bus_we         (bus_we),
      .bus_addr       (bus_addr),
      .bus_wdata      (bus_wdata),
      .bus_wmask      (bus_wmask),
      .bus_resp_valid (bus_resp_valid),
      .bus_rdata      (bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_req();
      req_valid = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_op    = 3'b000;
      addr      = '0;
      wdata     = '0;
   endtask

   task automatic put_req(input logic rd, input logic wr,
                          input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd);
      req_valid = 1'b1;
      mem_rd    = rd;
      mem_wr    = wr;
      mem_op    = op;
      addr      = a;
      wdata     = wd;
   endtask

   // Zero-wait bus access; x_lat 2 means a bus access is expected
   task automatic run_vec(input string tag, input logic rd, input logic wr,
                          input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rb,
                          input logic [31:0] x_rdata, input logic x_err,
                          input int x_lat, input logic x_we,
                          input logic [3:0] x_wm, input logic [31:0] x_wd);
      int lat;
      int nreq;
      logic [31:0] g_rd;
      logic [31:0] g_wd;
      logic [31:0] g_a;
      logic        g_err;
      logic        g_we;
      logic [3:0]  g_wm;
      g_wd = '0; g_a = '0; g_we = 1'b0; g_wm = '0;
      bus_req_ready  = 1'b1;
      bus_resp_valid = 1'b1;
      bus_rdata      = rb;
      put_req(rd, wr, op, a, wd);
      chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
      tick();
      clr_req();
      lat  = 1;
      nreq = 0;
      while (!resp_valid && lat < 50) begin
         if (bus_req_valid) begin
            nreq++;
            g_we = bus_we;
            g_wm = bus_wmask;
            g_wd = bus_wdata;
            g_a  = bus_addr;
         end
         tick();
         lat++;
      end
      g_rd  = rdata;
      g_err = resp_err;
      chk({tag, "_lat"}, 32'(lat), 32'(x_lat));
      chk({tag, "_nreq"}, 32'(nreq), (x_lat == 2) ? 32'd1 : 32'd0);
      chk({tag, "_rdata"}, g_rd, x_rdata);
      chk({tag, "_err"}, 32'(g_err), 32'(x_err));
      if (x_lat == 2) begin
         chk({tag, "_we"}, 32'(g_we), 32'(x_we));
         chk({tag, "_wm"}, 32'(g_wm), 32'(x_wm));
         chk({tag, "_wd"}, g_wd, x_wd);
         chk({tag, "_addr"}, g_a, {a[31:2], 2'b00});
      end
      resp_ready = 1'b1;
      tick();
      resp_ready     = 1'b0;
      bus_req_ready  = 1'b0;
      bus_resp_valid = 1'b0;
      bus_rdata      = '0;
      chk({tag, "_idle"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      int n;
      rst            = 1'b1;
      resp_ready     = 1'b0;
      bus_req_ready  = 1'b0;
      bus_resp_valid = 1'b0;
      bus_rdata      = '0;
      clr_req();
      tick();
      tick();
      rst = 1'b0;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_bus_req_valid", 32'(bus_req_valid), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_err", 32'(resp_err), 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_bus_wmask", 32'(bus_wmask), 32'd0);

      run_vec("lb", 1, 0, 3'b000, 32'h80000003, 0, 32'h80AABBCC,
              32'hFFFFFF80, 0, 2, 0, 4'b0000, 32'h0);
      run_vec("lbu", 1, 0, 3'b100, 32'h80000003, 0, 32'h80AABBCC,
              32'h00000080, 0, 2, 0, 4'b0000, 32'h0);
      run_vec("lb_pos", 1, 0, 3'b000, 32'h00000001, 0, 32'h00007F00,
              32'h0000007F, 0, 2, 0, 4'b0000, 32'h0);
      run_vec("lh", 1, 0, 3'b001, 32'h00000002, 0, 32'h80017FFF,
              32'hFFFF8001, 0, 2, 0, 4'b0000, 32'h0);
      run_vec("lhu", 1, 0, 3'b101, 32'h00000002, 0, 32'h80017FFF,
              32'h00008001, 0, 2, 0, 4'b0000, 32'h0);
      run_vec("lw", 1, 0, 3'b010, 32'h00000004, 0, 32'h12345678,
              32'h12345678, 0, 2, 0, 4'b0000, 32'h0);
      run_vec("sh", 0, 1, 3'b001, 32'h80000002, 32'h1234ABCD, 32'hDEADBEEF,
              32'h0, 0, 2, 1, 4'b1100, 32'hABCDABCD);
      run_vec("sb", 0, 1, 3'b000, 32'h00000001, 32'h000000A5, 32'hDEADBEEF,
              32'h0, 0, 2, 1, 4'b0010, 32'hA5A5A5A5);
      run_vec("sw", 0, 1, 3'b010, 32'h00000010, 32'hCAFEF00D, 32'h0,
              32'h0, 0, 2, 1, 4'b1111, 32'hCAFEF00D);
      run_vec("lw_mis", 1, 0, 3'b010, 32'h80000006, 0, 32'h0,
              32'h0, 1, 1, 0, 4'b0000, 32'h0);
      run_vec("lh_mis", 1, 0, 3'b001, 32'h00000001, 0, 32'h0,
              32'h0, 1, 1, 0, 4'b0000, 32'h0);
      run_vec("ld_op7", 1, 0, 3'b111, 32'h00000000, 0, 32'h0,
              32'h0, 1, 1, 0, 4'b0000, 32'h0);
      run_vec("st_op4", 0, 1, 3'b100, 32'h00000000, 0, 32'h0,
              32'h0, 1, 1, 0, 4'b0000, 32'h0);
      run_vec("rd_wr", 1, 1, 3'b010, 32'h00000000, 0, 32'h0,
              32'h0, 1, 1, 0, 4'b0000, 32'h0);
      run_vec("none", 0, 0, 3'b010, 32'h00000000, 0, 32'h0,
              32'h0, 0, 1, 0, 4'b0000, 32'h0);

      // Stalled bus: request held 5 cycles, response 3 cycles later
      put_req(1, 0, 3'b010, 32'h00000100, 0);
      tick();
      clr_req();
      for (int i = 0; i < 5; i++) begin
         chk("stall_req_valid", 32'(bus_req_valid), 32'd1);
         chk("stall_addr", bus_addr, 32'h00000100);
         tick();
      end
      bus_req_ready = 1'b1;
      tick();
      bus_req_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("stall_wait_req", 32'(bus_req_valid), 32'd0);
         chk("stall_wait_resp", 32'(resp_valid), 32'd0);
         tick();
      end
      bus_resp_valid = 1'b1;
      bus_rdata      = 32'hA5A51234;
      tick();
      bus_resp_valid = 1'b0;
      bus_rdata      = '0;
      for (int i = 0; i < 4; i++) begin
         chk("stall_hold_valid", 32'(resp_valid), 32'd1);
         chk("stall_hold_rdata", rdata, 32'hA5A51234);
         chk("stall_hold_rdy", 32'(req_ready), 32'd0);
         tick();
      end
      resp_ready = 1'b1;
      chk("stall_last_valid", 32'(resp_valid), 32'd1);
      tick();
      resp_ready = 1'b0;
      chk("stall_end_valid", 32'(resp_valid), 32'd0);
      chk("stall_end_rdy", 32'(req_ready), 32'd1);

      // Reset while waiting for a bus response
      bus_req_ready = 1'b1;
      put_req(1, 0, 3'b010, 32'h00000200, 0);
      tick();
      clr_req();
      tick();
      bus_req_ready = 1'b0;
      chk("wait_req_valid", 32'(bus_req_valid), 32'd0);
      chk("wait_rdy", 32'(req_ready), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_rdy", 32'(req_ready), 32'd1);
      chk("mid_rst_bus", 32'(bus_req_valid), 32'd0);
      bus_resp_valid = 1'b1;
      bus_rdata      = 32'h55555555;
      tick();
      bus_resp_valid = 1'b0;
      chk("late_resp_valid", 32'(resp_valid), 32'd0);
      chk("late_rdy", 32'(req_ready), 32'd1);
      tick();
      chk("late_resp_valid2", 32'(resp_valid), 32'd0);

      // Bus that never responds
      bus_req_ready = 1'b1;
      put_req(1, 0, 3'b010, 32'h00000300, 0);
      tick();
      clr_req();
`ifdef LSU_TIMEOUT_EN
      n = 0;
      while (!resp_valid && n < 100) begin
         tick();
         n++;
      end
      chk("to_cycles", 32'(n), 32'(TO));
      chk("to_err", 32'(resp_err), 32'd1);
      chk("to_rdata", rdata, 32'd0);
      chk("to_bus_req", 32'(bus_req_valid), 32'd0);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk("to_idle", 32'(req_ready), 32'd1);
`else
      n = 0;
      tick();
      bus_req_ready = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (resp_valid) n++;
         tick();
      end
      chk("nto_resp_seen", 32'(n), 32'd0);
      chk("nto_rdy", 32'(req_ready), 32'd0);
      chk("nto_bus_req", 32'(bus_req_valid), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("nto_rst_rdy", 32'(req_ready), 32'd1);
`endif
      bus_req_ready = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
